jk_bank_arbiter: RTL and testbench

JK_BANK_ARBITER -- requirements
Module: jk_bank_arbiter

---
 rtl/jk_arb_pkg.sv | 33 +++
 rtl/jk_cell_bank.sv | 33 +++
 rtl/jk_bank_arbiter.sv | 123 ++++++++++++
 tb/tb_jk_bank_arbiter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/jk_arb_pkg.sv
// Shared types and constants for the two-requester JK bank arbiter.
// Holds the arbiter state encoding, the default sizes and the per-bit JK command encoding.
package jk_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        G0   = 2'b01,
        G1   = 2'b10
    } arb_state_t;

    localparam int DEF_WIDTH     = 4;
    localparam int DEF_MAX_BURST = 4;

    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_CLR  = 2'b01,
        JK_SET  = 2'b10,
        JK_TOG  = 2'b11
    } jk_cmd_t;

    // Next value of one JK bit for a given {j,k} command.
    function automatic logic jk_bit(input logic j, input logic k, input logic q);
        logic nxt;
        case (jk_cmd_t'({j, k}))
            JK_HOLD: nxt = q;
            JK_CLR:  nxt = 1'b0;
            JK_SET:  nxt = 1'b1;
            default: nxt = ~q;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jk_cell_bank.sv
// WIDTH-bit bank of JK flip-flops with a common enable.
// Bits update only on enabled edges; synchronous reset clears the bank.
module jk_cell_bank
    import jk_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             res,
    input  logic             en,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_next;

    always_comb begin
        q_next = q;
        for (int i = 0; i < WIDTH; i++) begin
            q_next[i] = jk_bit(j[i], k[i], q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            q <= '0;
        end else if (en) begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Arbitrates two requesters onto one shared JK bank with burst-limited fairness.
// The granted requester's commands are applied one per edge while its request stays high.
module jk_bank_arbiter
    import jk_arb_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic             clk,
    input  logic             res,
    input  logic             req0,
    input  logic [WIDTH-1:0] j0,
    input  logic [WIDTH-1:0] k0,
    input  logic             req1,
    input  logic [WIDTH-1:0] j1,
    input  logic [WIDTH-1:0] k1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [WIDTH-1:0] q,
    output logic             busy
);

    localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

    arb_state_t       state, state_next;
    logic [3:0]       cnt, cnt_next;
    logic             last_served, last_served_next;
    logic             apply;
    logic [3:0]       cnt_inc;
    logic [WIDTH-1:0] j_sel, k_sel;

    assign cnt_inc = cnt + 4'd1;

    // Ties in IDLE go to whoever was not served last; a full burst hands over only if the other side waits.
    always_comb begin
        state_next       = state;
        cnt_next         = cnt;
        last_served_next = last_served;
        apply            = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = 4'd0;
                if (req0 && req1) begin
                    state_next = last_served ? G0 : G1;
                end else if (req0) begin
                    state_next = G0;
                end else if (req1) begin
                    state_next = G1;
                end
            end
            G0: begin
                if (!req0) begin
                    state_next       = req1 ? G1 : IDLE;
                    cnt_next         = 4'd0;
                    last_served_next = 1'b0;
                end else begin
                    apply = 1'b1;
                    if (cnt_inc == BURST_LIMIT) begin
                        cnt_next = 4'd0;
                        if (req1) begin
                            state_next       = G1;
                            last_served_next = 1'b0;
                        end
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end
            end
            G1: begin
                if (!req1) begin
                    state_next       = req0 ? G0 : IDLE;
                    cnt_next         = 4'd0;
                    last_served_next = 1'b1;
                end else begin
                    apply = 1'b1;
                    if (cnt_inc == BURST_LIMIT) begin
                        cnt_next = 4'd0;
                        if (req0) begin
                            state_next       = G0;
                            last_served_next = 1'b1;
                        end
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            last_served <= 1'b1;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            last_served <= last_served_next;
        end
    end

    assign gnt0  = (state == G0);
    assign gnt1  = (state == G1);
    assign busy  = gnt0 | gnt1;
    assign j_sel = gnt1 ? j1 : j0;
    assign k_sel = gnt1 ? k1 : k0;

    jk_cell_bank #(
        .WIDTH(WIDTH)
    ) u_bank (
        .clk(clk),
        .res(res),
        .en (apply),
        .j  (j_sel),
        .k  (k_sel),
        .q  (q)
    );

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed bench for jk_bank_arbiter: a vector table plus burst and reset corner sequences.
// A background monitor watches grant exclusivity and unexpected bank changes every edge.
module tb_jk_bank_arbiter;

    logic       clk;
    logic       res;
    logic       req0, req1;
    logic [3:0] j0, k0, j1, k1;
    logic       gnt0, gnt1, busy;
    logic [3:0] q;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       res;
        logic       req0;
        logic [3:0] j0;
        logic [3:0] k0;
        logic       req1;
        logic [3:0] j1;
        logic [3:0] k1;
        logic       g0;
        logic       g1;
        logic [3:0] q;
        string      name;
    } vec_t;

    vec_t vecs[16];

    jk_bank_arbiter #(
        .WIDTH    (4),
        .MAX_BURST(4)
    ) dut (
        .clk (clk),
        .res (res),
        .req0(req0),
        .j0  (j0),
        .k0  (k0),
        .req1(req1),
        .j1  (j1),
        .k1  (k1),
        .gnt0(gnt0),
        .gnt1(gnt1),
        .q   (q),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: outputs read at posedge are the values settled since the previous edge.
    logic       mon_armed = 1'b0;
    logic       mon_allow = 1'b1;
    logic [3:0] mon_prev_q = 4'h0;

    always @(posedge clk) begin
        if (mon_armed) begin
            checks++;
            if (gnt0 && gnt1) begin
                errors++;
                $display("[TB] FAIL grant_exclusive: gnt0=%b gnt1=%b, required not both high", gnt0, gnt1);
            end
            checks++;
            if (q !== mon_prev_q && !mon_allow) begin
                errors++;
                $display("[TB] FAIL q_stable: q=%b, required %b (no command or reset on that edge)", q, mon_prev_q);
            end
        end
        if (res) mon_armed = 1'b1;
        mon_allow  = res | (gnt0 & req0) | (gnt1 & req1);
        mon_prev_q = q;
    end

    task automatic applyStimulus(input logic r, input logic rq0, input logic [3:0] jj0, input logic [3:0] kk0,
                                 input logic rq1, input logic [3:0] jj1, input logic [3:0] kk1);
        res  = r;
        req0 = rq0;
        j0   = jj0;
        k0   = kk0;
        req1 = rq1;
        j1   = jj1;
        k1   = kk1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic eg0, input logic eg1, input logic [3:0] eq);
        checks++;
        if (gnt0 !== eg0 || gnt1 !== eg1 || busy !== (eg0 | eg1)) begin
            errors++;
            $display("[TB] FAIL %s grants: gnt0=%b gnt1=%b busy=%b, required %b %b %b",
                     name, gnt0, gnt1, busy, eg0, eg1, eg0 | eg1);
        end
        checks++;
        if (q !== eq) begin
            errors++;
            $display("[TB] FAIL %s q: got %b, required %b", name, q, eq);
        end
    endtask

    initial begin
        logic       eg0, eg1, pg0, pg1;
        logic [3:0] eq;

        res = 1'b1; req0 = 1'b0; req1 = 1'b0;
        j0 = 4'h0; k0 = 4'h0; j1 = 4'h0; k1 = 4'h0;

        //            res   req0  j0     k0     req1  j1     k1     g0    g1    q
        vecs[0]  = '{1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, "reset"};
        vecs[1]  = '{1'b0, 1'b1, 4'hF, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, "grant_latency"};
        vecs[2]  = '{1'b0, 1'b1, 4'hF, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'hF, "first_set"};
        vecs[3]  = '{1'b0, 1'b1, 4'hA, 4'h5, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'hA, "load_1010"};
        vecs[4]  = '{1'b0, 1'b1, 4'hF, 4'hF, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h5, "toggle_a"};
        vecs[5]  = '{1'b0, 1'b1, 4'hF, 4'hF, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'hA, "toggle_b_burst_end"};
        vecs[6]  = '{1'b0, 1'b1, 4'hF, 4'hF, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h5, "toggle_c"};
        vecs[7]  = '{1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 4'hF, 4'h0, 1'b1, 1'b0, 4'h5, "hold"};
        vecs[8]  = '{1'b0, 1'b1, 4'h3, 4'hC, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h3, "set_clr_mix"};
        vecs[9]  = '{1'b0, 1'b1, 4'h0, 4'h0, 1'b1, 4'hF, 4'h0, 1'b0, 1'b1, 4'h3, "handover_at_limit"};
        vecs[10] = '{1'b0, 1'b0, 4'hF, 4'hF, 1'b1, 4'h8, 4'h1, 1'b0, 1'b1, 4'hA, "g1_cmd"};
        vecs[11] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'hF, 4'hF, 1'b0, 1'b0, 4'hA, "g1_drop_idle"};
        vecs[12] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 4'hF, 4'hF, 1'b0, 1'b1, 4'hA, "g1_regrant"};
        vecs[13] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 4'hF, 4'hF, 1'b0, 1'b1, 4'h5, "g1_toggle"};
        vecs[14] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h5, "back_idle"};
        vecs[15] = '{1'b0, 1'b0, 4'hF, 4'h0, 1'b0, 4'hF, 4'h0, 1'b0, 1'b0, 4'h5, "idle_ignores_cmds"};

        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].res, vecs[i].req0, vecs[i].j0, vecs[i].k0,
                          vecs[i].req1, vecs[i].j1, vecs[i].k1);
            checkOutput(vecs[i].name, vecs[i].g0, vecs[i].g1, vecs[i].q);
        end

        // Simultaneous requests after reset: requester 0 first, 4-command bursts, no dead cycle.
        applyStimulus(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0);
        checkOutput("burst_reset", 1'b0, 1'b0, 4'h0);
        eq  = 4'h0;
        pg0 = 1'b0;
        pg1 = 1'b0;
        for (int e = 1; e <= 13; e++) begin
            if (pg0) eq = eq ^ 4'b0001;
            if (pg1) eq = eq ^ 4'b1000;
            eg0 = (e <= 4) || (e >= 9 && e <= 12);
            eg1 = (e >= 5 && e <= 8) || (e == 13);
            applyStimulus(1'b0, 1'b1, 4'b0001, 4'b0001, 1'b1, 4'b1000, 4'b1000);
            checkOutput($sformatf("burst_e%0d", e), eg0, eg1, eq);
            pg0 = eg0;
            pg1 = eg1;
        end

        // Reset pulse mid-burst aborts the grant; requester 0 wins the retry.
        applyStimulus(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0);
        checkOutput("abort_reset", 1'b0, 1'b0, 4'h0);
        applyStimulus(1'b0, 1'b1, 4'hF, 4'h0, 1'b1, 4'h0, 4'hF);
        checkOutput("abort_grant", 1'b1, 1'b0, 4'h0);
        applyStimulus(1'b0, 1'b1, 4'hF, 4'h0, 1'b1, 4'h0, 4'hF);
        checkOutput("abort_cmd1", 1'b1, 1'b0, 4'hF);
        applyStimulus(1'b0, 1'b1, 4'hF, 4'h0, 1'b1, 4'h0, 4'hF);
        checkOutput("abort_cmd2", 1'b1, 1'b0, 4'hF);
        applyStimulus(1'b1, 1'b1, 4'hF, 4'h0, 1'b1, 4'h0, 4'hF);
        checkOutput("abort_pulse", 1'b0, 1'b0, 4'h0);
        applyStimulus(1'b0, 1'b1, 4'hF, 4'h0, 1'b1, 4'h0, 4'hF);
        checkOutput("abort_retry", 1'b1, 1'b0, 4'h0);
        applyStimulus(1'b0, 1'b1, 4'hF, 4'h0, 1'b1, 4'h0, 4'hF);
        checkOutput("abort_retry_cmd", 1'b1, 1'b0, 4'hF);

        applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
